// File: rtl/forward_stall_unit.sv
// Operand forwarding across NSTAGES bypass sources with load-use and long-latency scoreboard stalls.
// Optional stall/forward statistics counters are built when FORWARD_STATS_EN is defined.
module forward_stall_unit #(
    parameter int NREAD   = 2,
    parameter int NSTAGES = 2,
    parameter int REGW    = 5,
    parameter int DATAW   = 32,
    parameter int MAXLAT  = 15,
    localparam int CW     = $clog2(MAXLAT + 1)
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     flush,
    input  logic [NREAD*REGW-1:0]    src_reg,
    input  logic [NREAD*DATAW-1:0]   src_rdat,
    output logic [NREAD*DATAW-1:0]   fwd_rdat,
    output logic [NREAD-1:0]         fwd_hit,
    input  logic [NSTAGES-1:0]       byp_wen,
    input  logic [NSTAGES*REGW-1:0]  byp_reg,
    input  logic [NSTAGES-1:0]       byp_ready,
    input  logic [NSTAGES*DATAW-1:0] byp_data,
    input  logic                     issue_en,
    input  logic [REGW-1:0]          issue_reg,
    input  logic [CW-1:0]            issue_lat,
    output logic                     stall,
    output logic [31:0]              stall_cnt,
    output logic [31:0]              fwd_cnt
);

    localparam int NREGS = 1 << REGW;

    logic [CW-1:0]    sb_reg [NREGS];
    logic [NREAD-1:0] port_stall;
    logic             issue_accept;

    generate
        for (genvar gi = 0; gi < NREAD; gi++) begin : g_port
            logic [REGW-1:0]  rd_idx;
            logic [DATAW-1:0] data_sel;
            logic             hit_sel;
            logic             stall_sel;
            logic             match_found;

            assign rd_idx = src_reg[gi*REGW +: REGW];

            // Youngest matching stage wins outright, even when its data is not ready yet.
            always_comb begin
                data_sel    = src_rdat[gi*DATAW +: DATAW];
                hit_sel     = 1'b0;
                stall_sel   = 1'b0;
                match_found = 1'b0;
                if (rd_idx != '0) begin
                    if (sb_reg[rd_idx] != '0) begin
                        stall_sel = 1'b1;
                    end else begin
                        for (int k = 0; k < NSTAGES; k++) begin
                            if (!match_found && byp_wen[k] &&
                                byp_reg[k*REGW +: REGW] == rd_idx) begin
                                match_found = 1'b1;
                                if (byp_ready[k]) begin
                                    hit_sel  = 1'b1;
                                    data_sel = byp_data[k*DATAW +: DATAW];
                                end else begin
                                    stall_sel = 1'b1;
                                end
                            end
                        end
                    end
                end
            end

            assign fwd_rdat[gi*DATAW +: DATAW] = data_sel;
            assign fwd_hit[gi]                 = hit_sel;
            assign port_stall[gi]              = stall_sel;
        end
    endgenerate

    assign stall        = |port_stall;
    assign issue_accept = issue_en && !stall && (issue_reg != '0) && (issue_lat != '0);

    // A freshly loaded entry skips its decrement; entry 0 never holds a count.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < NREGS; i++) begin
                sb_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (i == 0 || flush) begin
                    sb_reg[i] <= '0;
                end else if (issue_accept && issue_reg == REGW'(i)) begin
                    sb_reg[i] <= issue_lat;
                end else if (sb_reg[i] != '0) begin
                    sb_reg[i] <= sb_reg[i] - CW'(1);
                end
            end
        end
    end

`ifdef FORWARD_STATS_EN
    logic [31:0] stall_cnt_reg;
    logic [31:0] fwd_cnt_reg;

    // Both counters saturate rather than wrap; flush leaves them untouched.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt_reg <= '0;
            fwd_cnt_reg   <= '0;
        end else begin
            if (stall && stall_cnt_reg != '1) begin
                stall_cnt_reg <= stall_cnt_reg + 32'd1;
            end
            if (!stall && (|fwd_hit) && fwd_cnt_reg != '1) begin
                fwd_cnt_reg <= fwd_cnt_reg + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign fwd_cnt   = fwd_cnt_reg;
`else
    assign stall_cnt = '0;
    assign fwd_cnt   = '0;
`endif

endmodule

// File: tb/tb_forward_stall_unit.sv
// Directed bench for forward_stall_unit: expected outputs are queued with each stimulus and
// compared on the following falling edge.
module tb_forward_stall_unit;

    localparam int NREAD   = 2;
    localparam int NSTAGES = 2;
    localparam int REGW    = 5;
    localparam int DATAW   = 32;
    localparam int CW      = 4;

    localparam logic [31:0] S0 = 32'h1111_0000;
    localparam logic [31:0] S1 = 32'h2222_0000;

`ifdef FORWARD_STATS_EN
    localparam logic [31:0] EXP_STALL_CNT = 32'd4;
    localparam logic [31:0] EXP_FWD_CNT   = 32'd3;
`else
    localparam logic [31:0] EXP_STALL_CNT = 32'd0;
    localparam logic [31:0] EXP_FWD_CNT   = 32'd0;
`endif

    logic                     CLK = 1'b0;
    logic                     nRST;
    logic                     flush;
    logic [NREAD*REGW-1:0]    src_reg;
    logic [NREAD*DATAW-1:0]   src_rdat;
    logic [NREAD*DATAW-1:0]   fwd_rdat;
    logic [NREAD-1:0]         fwd_hit;
    logic [NSTAGES-1:0]       byp_wen;
    logic [NSTAGES*REGW-1:0]  byp_reg;
    logic [NSTAGES-1:0]       byp_ready;
    logic [NSTAGES*DATAW-1:0] byp_data;
    logic                     issue_en;
    logic [REGW-1:0]          issue_reg;
    logic [CW-1:0]            issue_lat;
    logic                     stall;
    logic [31:0]              stall_cnt;
    logic [31:0]              fwd_cnt;

    always #5 CLK = ~CLK;

    forward_stall_unit #(
        .NREAD(NREAD), .NSTAGES(NSTAGES), .REGW(REGW), .DATAW(DATAW), .MAXLAT(15)
    ) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .src_reg(src_reg), .src_rdat(src_rdat),
        .fwd_rdat(fwd_rdat), .fwd_hit(fwd_hit),
        .byp_wen(byp_wen), .byp_reg(byp_reg), .byp_ready(byp_ready), .byp_data(byp_data),
        .issue_en(issue_en), .issue_reg(issue_reg), .issue_lat(issue_lat),
        .stall(stall), .stall_cnt(stall_cnt), .fwd_cnt(fwd_cnt)
    );

    typedef struct {
        string       tag;
        logic        stall;
        logic [1:0]  hit;
        logic [31:0] d0;
        logic [31:0] d1;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic expect_out(input string tag, input logic s, input logic [1:0] h,
                              input logic [31:0] d0, input logic [31:0] d1);
        exp_t e;
        e.tag = tag; e.stall = s; e.hit = h; e.d0 = d0; e.d1 = d1;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            $display("txn %-12s stall=%b hit=%b d0=%h d1=%h", e.tag, stall, fwd_hit,
                     fwd_rdat[31:0], fwd_rdat[63:32]);
            check_val({e.tag, ".stall"}, {31'd0, stall}, {31'd0, e.stall});
            check_val({e.tag, ".hit"}, {30'd0, fwd_hit}, {30'd0, e.hit});
            check_val({e.tag, ".d0"}, fwd_rdat[31:0], e.d0);
            check_val({e.tag, ".d1"}, fwd_rdat[63:32], e.d1);
        end
    endtask

    task automatic cycle();
        @(negedge CLK);
        drain();
        @(posedge CLK);
        #1;
        issue_en = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic check_now();
        #1;
        drain();
    endtask

    task automatic set_src(input int p, input logic [REGW-1:0] r);
        src_reg[p*REGW +: REGW] = r;
    endtask

    task automatic set_byp(input int k, input logic w, input logic [REGW-1:0] r,
                           input logic rdy, input logic [31:0] d);
        byp_wen[k]                   = w;
        byp_reg[k*REGW +: REGW]      = r;
        byp_ready[k]                 = rdy;
        byp_data[k*DATAW +: DATAW]   = d;
    endtask

    task automatic clear_byp();
        set_byp(0, 1'b0, 5'd0, 1'b1, 32'd0);
        set_byp(1, 1'b0, 5'd0, 1'b1, 32'd0);
    endtask

    task automatic issue(input logic [REGW-1:0] r, input logic [CW-1:0] lat);
        issue_en  = 1'b1;
        issue_reg = r;
        issue_lat = lat;
    endtask

    initial begin
        nRST = 1'b0; flush = 1'b0;
        issue_en = 1'b0; issue_reg = '0; issue_lat = '0;
        src_reg = '0; src_rdat = {S1, S0};
        byp_wen = '0; byp_reg = '0; byp_ready = '0; byp_data = '0;

        #3;
        expect_out("reset", 1'b0, 2'b00, S0, S1);
        drain();
        check_val("reset.stall_cnt", stall_cnt, 32'd0);
        check_val("reset.fwd_cnt", fwd_cnt, 32'd0);
        #9 nRST = 1'b1;
        @(posedge CLK); #1;

        // Youngest-first priority and fall-through to an older stage
        set_byp(0, 1'b1, 5'd5, 1'b1, 32'h0000_AAAA);
        set_byp(1, 1'b1, 5'd5, 1'b1, 32'h0000_BBBB);
        set_src(0, 5'd5); set_src(1, 5'd3);
        expect_out("prio", 1'b0, 2'b01, 32'h0000_AAAA, S1); cycle();
        set_byp(0, 1'b0, 5'd5, 1'b1, 32'h0000_AAAA);
        set_src(1, 5'd5);
        expect_out("older", 1'b0, 2'b11, 32'h0000_BBBB, 32'h0000_BBBB); cycle();

        // Load-use: a not-ready younger match blocks the ready older one
        set_byp(0, 1'b1, 5'd7, 1'b0, 32'h0000_CCCC);
        set_byp(1, 1'b1, 5'd7, 1'b1, 32'h0000_DDDD);
        set_src(0, 5'd7); set_src(1, 5'd0);
        expect_out("lduse", 1'b1, 2'b00, S0, S1); cycle();
        set_byp(0, 1'b1, 5'd7, 1'b1, 32'h0000_CCCC);
        expect_out("lduse_rdy", 1'b0, 2'b01, 32'h0000_CCCC, S1); cycle();

        // Register 0 never forwards
        set_byp(0, 1'b1, 5'd0, 1'b1, 32'h0000_1234);
        set_byp(1, 1'b1, 5'd0, 1'b1, 32'h0000_1234);
        set_src(0, 5'd0); set_src(1, 5'd0);
        expect_out("zero", 1'b0, 2'b00, S0, S1); cycle();
        clear_byp();

        // Scoreboard: lat 3 gives exactly three stall cycles; issue while stalled is dropped
        issue(5'd9, 4'd3); set_src(0, 5'd1); set_src(1, 5'd2);
        expect_out("sb_issue", 1'b0, 2'b00, S0, S1); cycle();
        set_src(0, 5'd9);
        set_byp(0, 1'b1, 5'd9, 1'b1, 32'h0000_EEEE);
        issue(5'd10, 4'd15);
        expect_out("sb_wait1", 1'b1, 2'b00, S0, S1); cycle();
        clear_byp();
        expect_out("sb_wait2", 1'b1, 2'b00, S0, S1); cycle();
        expect_out("sb_wait3", 1'b1, 2'b00, S0, S1); cycle();
        expect_out("sb_done", 1'b0, 2'b00, S0, S1); cycle();
        set_src(0, 5'd10);
        expect_out("sb_ignored", 1'b0, 2'b00, S0, S1); cycle();

        // WAW overwrite: second issue's latency wins
        issue(5'd9, 4'd5); set_src(0, 5'd1);
        expect_out("waw_a", 1'b0, 2'b00, S0, S1); cycle();
        issue(5'd9, 4'd2);
        expect_out("waw_b", 1'b0, 2'b00, S0, S1); cycle();
        set_src(0, 5'd9);
        expect_out("waw_wait1", 1'b1, 2'b00, S0, S1); cycle();
        expect_out("waw_wait2", 1'b1, 2'b00, S0, S1); cycle();
        expect_out("waw_done", 1'b0, 2'b00, S0, S1); cycle();

        // Flush mid-countdown clears entries and drops a same-cycle issue
        issue(5'd11, 4'd8); set_src(0, 5'd1);
        expect_out("fl_issue", 1'b0, 2'b00, S0, S1); cycle();
        set_src(0, 5'd11);
        expect_out("fl_wait", 1'b1, 2'b00, S0, S1); cycle();
        set_src(0, 5'd1); flush = 1'b1; issue(5'd12, 4'd5);
        expect_out("fl_flush", 1'b0, 2'b00, S0, S1); cycle();
        set_src(0, 5'd11); set_src(1, 5'd12);
        expect_out("fl_after", 1'b0, 2'b00, S0, S1); cycle();

        // Asynchronous reset mid-countdown
        issue(5'd13, 4'd10); set_src(0, 5'd1); set_src(1, 5'd2);
        expect_out("rst_issue", 1'b0, 2'b00, S0, S1); cycle();
        set_src(0, 5'd13);
        expect_out("rst_pre", 1'b1, 2'b00, S0, S1); check_now();
        nRST = 1'b0;
        expect_out("rst_async", 1'b0, 2'b00, S0, S1); check_now();
        nRST = 1'b1;
        expect_out("rst_after", 1'b0, 2'b00, S0, S1); cycle();

        // Counters: 4 stall cycles then 3 forward cycles
        set_byp(0, 1'b1, 5'd7, 1'b0, 32'h0000_CCCC);
        set_src(0, 5'd7);
        for (int i = 0; i < 4; i++) begin
            expect_out("cnt_stall", 1'b1, 2'b00, S0, S1); cycle();
        end
        set_byp(0, 1'b1, 5'd7, 1'b1, 32'h0000_CCCC);
        for (int i = 0; i < 3; i++) begin
            expect_out("cnt_fwd", 1'b0, 2'b01, 32'h0000_CCCC, S1); cycle();
        end
        clear_byp(); set_src(0, 5'd1);
        check_val("cnt.stall_cnt", stall_cnt, EXP_STALL_CNT);
        check_val("cnt.fwd_cnt", fwd_cnt, EXP_FWD_CNT);
        flush = 1'b1;
        expect_out("cnt_flush", 1'b0, 2'b00, S0, S1); cycle();
        check_val("flush.stall_cnt", stall_cnt, EXP_STALL_CNT);
        check_val("flush.fwd_cnt", fwd_cnt, EXP_FWD_CNT);
        #2 nRST = 1'b0;
        #1;
        check_val("rst.stall_cnt", stall_cnt, 32'd0);
        check_val("rst.fwd_cnt", fwd_cnt, 32'd0);
        nRST = 1'b1;
        @(posedge CLK); #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
